// File: rtl/pvt_apb_pkg.sv
// Shared types and helpers for the PVT APB poller.
//   state_e   : sequencing states of the poller
//   REG_*     : register index within a sensor group
//   reg_addr  : byte address of register r in group g
package pvt_apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_P    = 2'd1;
  localparam logic [1:0] REG_V    = 2'd2;
  localparam logic [1:0] REG_T    = 2'd3;

  // Each group spans four 32-bit words, so address = (g*4 + r)*4.
  function automatic logic [31:0] reg_addr(input logic [31:0] g, input logic [1:0] r);
    reg_addr = {g[27:0], r, 2'b00};
  endfunction

endpackage

// File: rtl/pvt_apb_poller_if.sv
// APB link between the poller (requester) and the PVT sensor completer.
//   master : addr/sel/enable/write/wdata/wstrb out, rdata/ready/slverr in
//   slave  : the mirror image, used by the completer
interface pvt_apb_poller_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] m_apb_addr;
  logic                  m_apb_sel;
  logic                  m_apb_enable;
  logic                  m_apb_write;
  logic [31:0]           m_apb_wdata;
  logic [3:0]            m_apb_wstrb;
  logic [31:0]           m_apb_rdata;
  logic                  m_apb_ready;
  logic                  m_apb_slverr;

  modport master (
    output m_apb_addr, m_apb_sel, m_apb_enable, m_apb_write, m_apb_wdata, m_apb_wstrb,
    input  m_apb_rdata, m_apb_ready, m_apb_slverr
  );

  modport slave (
    input  m_apb_addr, m_apb_sel, m_apb_enable, m_apb_write, m_apb_wdata, m_apb_wstrb,
    output m_apb_rdata, m_apb_ready, m_apb_slverr
  );
endinterface

// File: rtl/pvt_apb_xfer.sv
// Single APB transfer engine: drives SETUP then ACCESS from registered
// outputs, counts ACCESS cycles for the timeout and reports completion.
//   clk, rst            : clock, async active-high reset
//   req                 : launch a transfer; next cycle is its SETUP phase
//                         (may be raised on the completing ACCESS cycle to chain)
//   req_addr/write/wdata: transfer attributes, sampled with req
//   xfer_done           : current ACCESS cycle completes without error
//   xfer_err            : current ACCESS cycle ends with slverr or timeout
//   apb                 : APB requester signals
module pvt_apb_xfer #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [31:0]           req_wdata,
  output logic                  xfer_done,
  output logic                  xfer_err,
  pvt_apb_poller_if.master      apb
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] tcnt_r;
  logic          access_s;
  logic          complete_s;
  logic          timeout_s;

  // Completion and abort decode for the current ACCESS cycle.
  always_comb begin
    access_s   = apb.m_apb_sel & apb.m_apb_enable;
    complete_s = access_s & apb.m_apb_ready;
    // Ready arriving on the last allowed cycle still wins over the timeout.
    timeout_s  = access_s & ~apb.m_apb_ready & (tcnt_r == LAST_CNT);
    xfer_done  = complete_s & ~apb.m_apb_slverr;
    xfer_err   = (complete_s & apb.m_apb_slverr) | timeout_s;
  end

  // APB phase registers and ACCESS-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apb.m_apb_sel    <= 1'b0;
      apb.m_apb_enable <= 1'b0;
      apb.m_apb_addr   <= '0;
      apb.m_apb_write  <= 1'b0;
      apb.m_apb_wdata  <= 32'h0;
      apb.m_apb_wstrb  <= 4'h0;
      tcnt_r           <= '0;
    end else if (req) begin
      apb.m_apb_sel    <= 1'b1;
      apb.m_apb_enable <= 1'b0;
      apb.m_apb_addr   <= req_addr;
      apb.m_apb_write  <= req_write;
      apb.m_apb_wdata  <= req_write ? req_wdata : 32'h0;
      apb.m_apb_wstrb  <= req_write ? 4'hf : 4'h0;
      tcnt_r           <= '0;
    end else if (apb.m_apb_sel & ~apb.m_apb_enable) begin
      apb.m_apb_enable <= 1'b1;
    end else if (complete_s | timeout_s) begin
      apb.m_apb_sel    <= 1'b0;
      apb.m_apb_enable <= 1'b0;
    end else if (access_s) begin
      tcnt_r <= tcnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/pvt_apb_poller.sv
// Sweeps every PVT sensor group over APB: writes ctrl_word to each group's
// control register, reads its P/V/T registers and streams each read out.
//   m_apb_clk, m_apb_rst : clock, async active-high reset
//   start, ctrl_word     : sweep request and control value (latched on start)
//   busy, done, err      : sweep status (err sticky until next start)
//   apb                  : APB requester link
//   res_valid/ready/data/group/reg : result stream, one beat per read
module pvt_apb_poller
  import pvt_apb_pkg::*;
#(
  parameter int NO_OF_GROUPS = 10,
  parameter int ADDR_WIDTH   = $clog2(NO_OF_GROUPS * 4) + 2,
  parameter int TIMEOUT      = 16,
  parameter int GROUP_WIDTH  = (NO_OF_GROUPS > 1) ? $clog2(NO_OF_GROUPS) : 1
) (
  input  logic                   m_apb_clk,
  input  logic                   m_apb_rst,
  input  logic                   start,
  input  logic [31:0]            ctrl_word,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  pvt_apb_poller_if.master       apb,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [GROUP_WIDTH-1:0] res_group,
  output logic [1:0]             res_reg
);

  localparam logic [GROUP_WIDTH-1:0] LAST_GROUP = GROUP_WIDTH'(NO_OF_GROUPS - 1);

  state_e                  state_r, state_s;
  logic [GROUP_WIDTH-1:0]  g_r, next_g_s;
  logic [1:0]              r_r, next_r_s;
  logic [31:0]             ctrl_r;
  logic                    busy_r, done_r, err_r, res_valid_r;
  logic [31:0]             res_data_r;
  logic [GROUP_WIDTH-1:0]  res_group_r;
  logic [1:0]              res_reg_r;
  logic                    req_s, start_s, capture_s, abort_s;
  logic [ADDR_WIDTH-1:0]   req_addr_s;
  logic                    req_write_s;
  logic [31:0]             req_wdata_s;
  logic                    xfer_done_s, xfer_err_s;

  pvt_apb_xfer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) u_xfer (
    .clk       (m_apb_clk),
    .rst       (m_apb_rst),
    .req       (req_s),
    .req_addr  (req_addr_s),
    .req_write (req_write_s),
    .req_wdata (req_wdata_s),
    .xfer_done (xfer_done_s),
    .xfer_err  (xfer_err_s),
    .apb       (apb)
  );

  // Sequencing: next state and the (g, r) of the transfer being launched.
  always_comb begin
    state_s   = state_r;
    req_s     = 1'b0;
    start_s   = 1'b0;
    capture_s = 1'b0;
    abort_s   = 1'b0;
    next_g_s  = g_r;
    next_r_s  = r_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_s  = 1'b1;
          req_s    = 1'b1;
          next_g_s = '0;
          next_r_s = REG_CTRL;
          state_s  = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: state_s = ACCESS;
      ACCESS: begin
        if (xfer_err_s) begin
          abort_s = 1'b1;
          state_s = DONE;
        end else if (xfer_done_s) begin
          if (r_r == REG_CTRL) begin
            // Control write done: chain straight into the first data read.
            req_s    = 1'b1;
            next_r_s = REG_P;
            state_s  = SETUP;
          end else begin
            capture_s = 1'b1;
            state_s   = RESULT;
          end
        end else begin
          state_s = ACCESS;
        end
      end
      RESULT: begin
        if (!res_ready) begin
          state_s = RESULT;
        end else if ((g_r == LAST_GROUP) && (r_r == REG_T)) begin
          state_s = DONE;
        end else begin
          req_s   = 1'b1;
          state_s = SETUP;
          case (r_r)
            REG_P:   next_r_s = REG_V;
            REG_V:   next_r_s = REG_T;
            REG_T: begin
              next_g_s = g_r + GROUP_WIDTH'(1);
              next_r_s = REG_CTRL;
            end
            default: next_r_s = REG_CTRL;
          endcase
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Attributes of the launched transfer; on start ctrl_r is not yet loaded.
  always_comb begin
    req_addr_s  = ADDR_WIDTH'(reg_addr(32'(next_g_s), next_r_s));
    req_write_s = (next_r_s == REG_CTRL);
    if (start_s) begin
      req_wdata_s = ctrl_word;
    end else begin
      req_wdata_s = ctrl_r;
    end
  end

  // State register.
  always_ff @(posedge m_apb_clk or posedge m_apb_rst) begin
    if (m_apb_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Sweep position, latched control word, status flags and result beat.
  always_ff @(posedge m_apb_clk or posedge m_apb_rst) begin
    if (m_apb_rst) begin
      g_r         <= '0;
      r_r         <= 2'd0;
      ctrl_r      <= 32'h0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= 32'h0;
      res_group_r <= '0;
      res_reg_r   <= 2'd0;
    end else begin
      if (req_s) begin
        g_r <= next_g_s;
        r_r <= next_r_s;
      end
      if (start_s) begin
        ctrl_r <= ctrl_word;
        err_r  <= 1'b0;
      end else if (abort_s) begin
        err_r <= 1'b1;
      end
      busy_r      <= (state_s == SETUP) || (state_s == ACCESS) || (state_s == RESULT);
      done_r      <= (state_s == DONE);
      res_valid_r <= (state_s == RESULT);
      if (capture_s) begin
        res_data_r  <= apb.m_apb_rdata;
        res_group_r <= g_r;
        res_reg_r   <= r_r;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_group = res_group_r;
  assign res_reg   = res_reg_r;

endmodule

// File: tb/tb_pvt_apb_poller.sv
// Self-checking bench for pvt_apb_poller: a behavioural completer with
// per-word random read data, a transfer/beat scoreboard built from the sweep
// order (group by group: write ctrl, read P, V, T) and directed plus random
// sweeps covering wait states, back-pressure, slverr, timeout and reset.
module tb_pvt_apb_poller;

  localparam int NG = 10;
  localparam int AW = 8;

  typedef struct {
    int          addr;
    bit          wr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    int          g;
    int          r;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ctrl_word;
  logic        busy, done, err;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_group;
  logic [1:0]  res_reg;

  pvt_apb_poller_if #(.ADDR_WIDTH(AW)) bus ();

  pvt_apb_poller #(.NO_OF_GROUPS(NG), .ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .m_apb_clk (clk),
    .m_apb_rst (rst),
    .start     (start),
    .ctrl_word (ctrl_word),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .apb       (bus),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_group (res_group),
    .res_reg   (res_reg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scenario knobs and scoreboard state.
  logic [31:0] mem [0:63];
  xfer_t xq[$];
  beat_t bq[$];
  int waits = 0, err_addr = -1, hang_addr = -1;
  bit rnd_wait = 1'b0, rnd_ready = 1'b0;
  int hold_g = -1, hold_r = -1, hold_cnt = 0;
  int acc_len = 0, wtarget = 0, hang_len = 0;
  int beats_seen = 0, beats_exp = 0;
  bit prev_stall = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_group;
  logic [1:0]  held_reg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected transfers and beats from the sweep order, cut at an error.
  task automatic build_model(input logic [31:0] cw);
    int stop;
    bit stop_done;
    xfer_t x;
    beat_t b;
    xq.delete();
    bq.delete();
    beats_exp = 0;
    stop = -1;
    stop_done = 1'b0;
    if (err_addr >= 0) begin
      stop = err_addr / 4;
      stop_done = 1'b1;
    end else if (hang_addr >= 0) begin
      stop = hang_addr / 4;
    end
    for (int i = 0; i < NG * 4; i++) begin
      if (stop >= 0 && i > stop) break;
      x.addr  = i * 4;
      x.wr    = ((i % 4) == 0);
      x.wdata = cw;
      if (!(i == stop && !stop_done)) xq.push_back(x);
      if ((i % 4) != 0 && i != stop) begin
        b.g = i / 4;
        b.r = i % 4;
        b.data = mem[i];
        bq.push_back(b);
        beats_exp++;
      end
    end
  endtask

  // Completer, result sink and scoreboard, all acting between clock edges.
  always @(negedge clk) begin
    xfer_t e;
    beat_t b;
    if (rst) begin
      bus.m_apb_ready  = 1'b0;
      bus.m_apb_slverr = 1'b0;
      acc_len = 0;
      prev_stall = 1'b0;
    end else begin
      if (bus.m_apb_sel && bus.m_apb_enable) begin
        if (acc_len == 0) wtarget = rnd_wait ? int'($urandom_range(0, 3)) : waits;
        acc_len++;
        if (int'(bus.m_apb_addr) == hang_addr) begin
          hang_len++;
          bus.m_apb_ready = 1'b0;
        end else begin
          bus.m_apb_ready = (acc_len > wtarget);
        end
        bus.m_apb_slverr = bus.m_apb_ready && (int'(bus.m_apb_addr) == err_addr);
        bus.m_apb_rdata  = mem[bus.m_apb_addr[7:2]];
        if (bus.m_apb_ready) begin
          chk("xfer_pending", 32'(xq.size() > 0), 32'd1);
          if (xq.size() > 0) begin
            e = xq.pop_front();
            chk("xfer_addr", 32'(bus.m_apb_addr), 32'(e.addr));
            chk("xfer_write", 32'(bus.m_apb_write), 32'(e.wr));
            chk("xfer_wstrb", 32'(bus.m_apb_wstrb), e.wr ? 32'hf : 32'h0);
            if (e.wr) chk("xfer_wdata", bus.m_apb_wdata, e.wdata);
          end
        end
      end else begin
        acc_len = 0;
        bus.m_apb_ready  = 1'b0;
        bus.m_apb_slverr = 1'b0;
        bus.m_apb_rdata  = $urandom;
      end

      if (rnd_ready) begin
        res_ready = 1'($urandom_range(0, 1));
      end else if (res_valid && int'(res_group) == hold_g && int'(res_reg) == hold_r
                   && hold_cnt < 5) begin
        res_ready = 1'b0;
        hold_cnt++;
      end else begin
        res_ready = 1'b1;
      end

      if (res_valid) begin
        chk("apb_idle_in_result", 32'(bus.m_apb_sel), 32'd0);
        if (prev_stall) begin
          chk("stall_data", res_data, held_data);
          chk("stall_group", 32'(res_group), 32'(held_group));
          chk("stall_reg", 32'(res_reg), 32'(held_reg));
        end
        if (res_ready) begin
          chk("beat_pending", 32'(bq.size() > 0), 32'd1);
          if (bq.size() > 0) begin
            b = bq.pop_front();
            chk("beat_group", 32'(res_group), 32'(b.g));
            chk("beat_reg", 32'(res_reg), 32'(b.r));
            chk("beat_data", res_data, b.data);
          end
          beats_seen++;
        end
      end
      prev_stall = res_valid && !res_ready;
      held_data  = res_data;
      held_group = res_group;
      held_reg   = res_reg;
    end
  end

  // One full sweep; exp_cyc counts cycles from SETUP of g0 to done (0 = skip).
  task automatic sweep(input logic [31:0] cw, input int exp_cyc, input bit exp_err);
    int cyc;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    build_model(cw);
    hang_len = 0;
    hold_cnt = 0;
    beats_seen = 0;
    ctrl_word = cw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", 32'(busy), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      // A start while busy must be ignored, including its new ctrl_word.
      if (cyc == 20) begin
        start = 1'b1;
        ctrl_word = ~cw;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    if (exp_cyc > 0) chk("sweep_cycles", 32'(cyc), 32'(exp_cyc));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("err_at_done", 32'(err), 32'(exp_err));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("xfers_left", 32'(xq.size()), 32'd0);
    chk("beats_left", 32'(bq.size()), 32'd0);
    chk("beat_count", 32'(beats_seen), 32'(beats_exp));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    res_ready = 1'b1;
    ctrl_word = 32'h0;
    bus.m_apb_ready = 1'b0;
    bus.m_apb_slverr = 1'b0;
    bus.m_apb_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sel", 32'(bus.m_apb_sel), 32'd0);
    chk("rst_enable", 32'(bus.m_apb_enable), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_addr", 32'(bus.m_apb_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait sweep with the reference control word.
    sweep(32'h0001_FFC3, NG * 11, 1'b0);
    // Three wait states per access: every ACCESS is 4 cycles.
    waits = 3;
    sweep($urandom, NG * (4 * (2 + 3) + 3), 1'b0);
    waits = 0;
    // Back-pressure on beat (2,2) for five cycles.
    hold_g = 2;
    hold_r = 2;
    sweep($urandom, NG * 11 + 5, 1'b0);
    hold_g = -1;
    hold_r = -1;
    // slverr on read (4,1): abort, no beat for it.
    err_addr = (4 * 4 + 1) * 4;
    sweep($urandom, 0, 1'b1);
    err_addr = -1;
    // Completer never readies the first control write: timeout after 16 cycles.
    hang_addr = 0;
    sweep($urandom, 1 + 16, 1'b1);
    chk("timeout_len", 32'(hang_len), 32'd16);
    hang_addr = -1;
    // The next start clears err and sweeps normally.
    sweep($urandom, NG * 11, 1'b0);

    // Reset in the middle of an ACCESS phase.
    waits = 3;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    build_model(32'h5A5A_0001);
    ctrl_word = 32'h5A5A_0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !bus.m_apb_enable; i++) @(negedge clk);
    chk("mid_access_reached", 32'(bus.m_apb_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(bus.m_apb_sel), 32'd0);
    chk("mid_rst_enable", 32'(bus.m_apb_enable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xq.delete();
    bq.delete();
    repeat (3) @(negedge clk);
    chk("post_rst_sel", 32'(bus.m_apb_sel), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    waits = 0;

    // Random wait states, random back-pressure, occasional slverr.
    rnd_wait = 1'b1;
    rnd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      err_addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NG * 4 - 1)) * 4 : -1;
      sweep($urandom, 0, err_addr >= 0);
    end
    err_addr = -1;
    rnd_wait = 1'b0;
    rnd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
